// File: rtl/nac_mem_arbiter.sv
// Shared memory port arbiter for fetch and data requesters.
// In-order read tag FIFO routes responses and drops flushed fetches.
module nac_mem_arbiter #(
    parameter int OUTST_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [31:0]           f_addr,
    input  logic                  f_req,
    output logic                  f_grant,
    output logic                  f_valid,
    output logic [31:0]           f_rdata,
    input  logic [31:0]           d_addr,
    input  logic [31:0]           d_wdata,
    input  logic                  d_req,
    input  logic                  d_we,
    output logic                  d_grant,
    output logic                  d_valid,
    output logic [31:0]           d_rdata,
    output logic [31:0]           m_addr,
    output logic [31:0]           m_wdata,
    output logic                  m_req,
    output logic                  m_we,
    input  logic                  m_grant,
    input  logic                  m_valid,
    input  logic [31:0]           m_rdata,
    output logic [OUTST_LOG2:0]   outstanding,
    output logic                  err_unexp
);

    localparam int OUTST = 1 << OUTST_LOG2;
    localparam int CW    = OUTST_LOG2 + 1;
    localparam int PW    = OUTST_LOG2;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            own_f_q, own_f_d;
    logic            kill_cur_q, kill_cur_d;
    logic            prio_f_q, prio_f_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [OUTST-1:0] tag_f_q, tag_f_d;
    logic [OUTST-1:0] tag_k_q, tag_k_d;

    logic room;
    logic f_elig;
    logic d_elig;
    logic pick_f;
    logic granted;
    logic push;
    logic pop;
    logic head_f;
    logic head_k;

    always_comb begin
        room    = cnt_q < CW'(OUTST);
        f_elig  = f_req && room;
        d_elig  = d_req && (d_we || room);
        pick_f  = f_elig && (!d_elig || prio_f_q);
        granted = (state_q == ISSUE) && m_grant;
        push    = granted && !we_q;
        pop     = m_valid && (cnt_q != '0);
        head_f  = tag_f_q[rptr_q];
        // a fetch popped under flush is as dead as one already marked
        head_k  = tag_k_q[rptr_q] || (flush && head_f);
    end

    always_comb begin
        f_grant     = granted && own_f_q && !kill_cur_q;
        d_grant     = granted && !own_f_q;
        f_valid     = pop && head_f && !head_k;
        d_valid     = pop && !head_f;
        f_rdata     = f_valid ? m_rdata : '0;
        d_rdata     = d_valid ? m_rdata : '0;
        m_req       = (state_q == ISSUE);
        m_addr      = addr_q;
        m_wdata     = wdata_q;
        m_we        = we_q;
        outstanding = cnt_q;
        err_unexp   = err_q;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        own_f_d    = own_f_q;
        kill_cur_d = kill_cur_q;
        prio_f_d   = prio_f_q;
        unique case (state_q)
            IDLE: begin
                if (f_elig || d_elig) begin
                    state_d    = ISSUE;
                    own_f_d    = pick_f;
                    addr_d     = pick_f ? f_addr : d_addr;
                    we_d       = pick_f ? 1'b0 : d_we;
                    wdata_d    = pick_f ? '0 : d_wdata;
                    kill_cur_d = 1'b0;
                end
            end
            ISSUE: begin
                if (m_grant) begin
                    state_d    = IDLE;
                    kill_cur_d = 1'b0;
                    prio_f_d   = !own_f_q;
                end else if (flush && own_f_q) begin
                    kill_cur_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tag_f_d = tag_f_q;
        tag_k_d = tag_k_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        err_d   = err_q;
        if (flush) begin
            tag_k_d = tag_k_q | tag_f_q;
        end
        if (push) begin
            tag_f_d[wptr_q] = own_f_q;
            tag_k_d[wptr_q] = own_f_q && (kill_cur_q || flush);
            wptr_d          = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        if (m_valid && (cnt_q == '0)) begin
            err_d = 1'b1;
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            own_f_q    <= 1'b0;
            kill_cur_q <= 1'b0;
            prio_f_q   <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            tag_f_q    <= '0;
            tag_k_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            own_f_q    <= own_f_d;
            kill_cur_q <= kill_cur_d;
            prio_f_q   <= prio_f_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            tag_f_q    <= tag_f_d;
            tag_k_q    <= tag_k_d;
        end
    end

endmodule
